// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcodes, funct3 codes and the immediate-format enum for the immediate generator.
package immgen_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(parameter int unsigned XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instrucao;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imediatoGerado;
    logic [2:0]      imm_fmt;
    logic            imm_illegal;

    modport master (
        output in_valid, instrucao, out_ready,
        input  in_ready, out_valid, imediatoGerado, imm_fmt, imm_illegal
    );

    modport slave (
        input  in_valid, instrucao, out_ready,
        output in_ready, out_valid, imediatoGerado, imm_fmt, imm_illegal
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder.
// IMMGEN_CSR_EN: when defined, SYSTEM opcodes with funct3[2]=1 yield fmt Z (zimm).
module imm_decode
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        shamt_hi;
    logic [31:0] imm32;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign shamt_hi = (XLEN == 64) ? instr[25] : 1'b0;

    always_comb begin
        fmt     = FMT_NONE;
        imm32   = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OPIMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRX) begin
                    fmt   = FMT_SH;
                    imm32 = {26'd0, shamt_hi, instr[24:20]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
                if (funct3[2]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'd0, instr[19:15]};
                end
`endif
            end
            OPC_OP, OPC_FENCE: begin
            end
            default: illegal = 1'b1;
        endcase
    end

    // SH and Z immediates have bit 31 clear, so one sign-extension covers every format.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic-pipelined immediate generator: decode, optional input register, output register.
// Build option IMMGEN_CSR_EN is consumed by imm_decode.
module imm_gen_pipe
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    imm_gen_pipe_if.slave bus
);
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.instrucao),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    logic            src_valid;
    fmt_e            src_fmt;
    logic [XLEN-1:0] src_imm;
    logic            src_illegal;

    logic            o_valid;
    fmt_e            o_fmt;
    logic [XLEN-1:0] o_imm;
    logic            o_illegal;
    logic            o_ready;
    logic            src_take;

    assign o_ready  = !o_valid | bus.out_ready;
    assign src_take = src_valid & o_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two
            logic            s1_valid;
            fmt_e            s1_fmt;
            logic [XLEN-1:0] s1_imm;
            logic            s1_illegal;

            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_valid   <= 1'b0;
                    s1_fmt     <= FMT_NONE;
                    s1_imm     <= '0;
                    s1_illegal <= 1'b0;
                end else begin
                    if (bus.in_ready)
                        s1_valid <= bus.in_valid;
                    if (bus.in_valid && bus.in_ready) begin
                        s1_fmt     <= dec_fmt;
                        s1_imm     <= dec_imm;
                        s1_illegal <= dec_illegal;
                    end
                end
            end

            assign src_valid    = s1_valid;
            assign src_fmt      = s1_fmt;
            assign src_imm      = s1_imm;
            assign src_illegal  = s1_illegal;
            assign bus.in_ready = !s1_valid | src_take;
        end else begin : g_one
            // Output register is the only stage; decode feeds it directly.
            assign src_valid    = bus.in_valid;
            assign src_fmt      = dec_fmt;
            assign src_imm      = dec_imm;
            assign src_illegal  = dec_illegal;
            assign bus.in_ready = o_ready;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_fmt     <= FMT_NONE;
            o_imm     <= '0;
            o_illegal <= 1'b0;
        end else begin
            if (o_ready)
                o_valid <= src_valid;
            if (src_take) begin
                o_fmt     <= src_fmt;
                o_imm     <= src_imm;
                o_illegal <= src_illegal;
            end
        end
    end

    assign bus.out_valid      = o_valid;
    assign bus.imediatoGerado = o_imm;
    assign bus.imm_fmt        = o_fmt;
    assign bus.imm_illegal    = o_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit two-stage instance and a 64-bit one-stage instance.
module tb_imm_gen_pipe;
    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    imm_gen_pipe_if #(.XLEN(32)) bus_a ();
    imm_gen_pipe_if #(.XLEN(64)) bus_b ();

    imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic out_a(input string tag, input logic v, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"}, 64'(bus_a.out_valid), 64'(v));
        chk({tag, "_imm"},   64'(bus_a.imediatoGerado), 64'(imm));
        chk({tag, "_fmt"},   64'(bus_a.imm_fmt), 64'(fmt));
        chk({tag, "_ill"},   64'(bus_a.imm_illegal), 64'(ill));
    endtask

    task automatic out_b(input string tag, input logic v, input logic [63:0] imm,
                         input logic [2:0] fmt);
        chk({tag, "_valid"}, 64'(bus_b.out_valid), 64'(v));
        chk({tag, "_imm"},   bus_b.imediatoGerado, imm);
        chk({tag, "_fmt"},   64'(bus_b.imm_fmt), 64'(fmt));
    endtask

    task automatic push_a(input logic [31:0] ins);
        bus_a.in_valid  = 1'b1;
        bus_a.instrucao = ins;
        step();
    endtask

    task automatic idle_a();
        bus_a.in_valid = 1'b0;
        step();
    endtask

    localparam logic [31:0] ADDI  = 32'hFFF00093;
    localparam logic [31:0] SW    = 32'hFE112E23;
    localparam logic [31:0] BEQ   = 32'hFE000CE3;
    localparam logic [31:0] JAL   = 32'h0010006F;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] SLLI  = 32'h00509093;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] RTYP  = 32'h002081B3;
    localparam logic [31:0] CSRWI = 32'h3400D073;

    initial begin
        reset           = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.instrucao = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.instrucao = '0;
        bus_b.out_ready = 1'b1;
        repeat (2) step();

        out_a("rst_a", 1'b0, 32'h0, 3'd0, 1'b0);
        out_b("rst_b", 1'b0, 64'h0, 3'd0);
        reset = 1'b0;
        step();
        chk("rdy_a_after_rst", 64'(bus_a.in_ready), 64'd1);
        chk("rdy_b_after_rst", 64'(bus_b.in_ready), 64'd1);

        // addi then sw back to back: two cycles of latency, one per cycle throughput
        bus_a.in_valid  = 1'b1;
        bus_a.instrucao = ADDI;
        #1 chk("rdy_a_addi", 64'(bus_a.in_ready), 64'd1);
        step();
        push_a(SW);
        out_a("addi", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        idle_a();
        out_a("sw", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0);
        step();
        out_a("sw_drained", 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0);

        push_a(BEQ);
        push_a(JAL);
        out_a("beq", 1'b1, 32'hFFFFFFF8, 3'd3, 1'b0);
        push_a(LUI);
        out_a("jal", 1'b1, 32'h00000800, 3'd5, 1'b0);
        idle_a();
        out_a("lui", 1'b1, 32'h12345000, 3'd4, 1'b0);

        push_a(SLLI);
        idle_a();
        out_a("slli", 1'b1, 32'h00000005, 3'd6, 1'b0);

        push_a(ILL);
        push_a(RTYP);
        out_a("illegal", 1'b1, 32'h0, 3'd0, 1'b1);
        idle_a();
        out_a("rtype", 1'b1, 32'h0, 3'd0, 1'b0);

        // Four-instruction stream with out_ready low for three cycles
        idle_a();
        push_a(ADDI);
        bus_a.out_ready = 1'b0;
        push_a(SW);
        out_a("bp_a0", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        bus_a.instrucao = SLLI;
        #1 chk("bp_rdy0", 64'(bus_a.in_ready), 64'd0);
        step();
        out_a("bp_a1", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        chk("bp_rdy1", 64'(bus_a.in_ready), 64'd0);
        step();
        out_a("bp_a2", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        bus_a.out_ready = 1'b1;
        #1 chk("bp_rdy_release", 64'(bus_a.in_ready), 64'd1);
        step();
        out_a("bp_b", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0);
        push_a(LUI);
        out_a("bp_c", 1'b1, 32'h00000005, 3'd6, 1'b0);
        idle_a();
        out_a("bp_d", 1'b1, 32'h12345000, 3'd4, 1'b0);
        step();
        chk("bp_empty", 64'(bus_a.out_valid), 64'd0);

        // 64-bit single-stage instance
        bus_b.in_valid  = 1'b1;
        bus_b.instrucao = ADDI;
        step();
        out_b("b_addi", 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        bus_b.instrucao = 32'h800000B7;
        step();
        out_b("b_lui_neg", 1'b1, 64'hFFFFFFFF80000000, 3'd4);
        bus_b.instrucao = 32'h03F09093;
        step();
        out_b("b_slli63", 1'b1, 64'd63, 3'd6);
        bus_b.out_ready = 1'b0;
        bus_b.instrucao = LUI;
        #1 chk("b_rdy_stall", 64'(bus_b.in_ready), 64'd0);
        step();
        out_b("b_hold", 1'b1, 64'd63, 3'd6);
        bus_b.out_ready = 1'b1;
        step();
        out_b("b_lui", 1'b1, 64'h0000000012345000, 3'd4);
        bus_b.in_valid = 1'b0;
        step();
        chk("b_empty", 64'(bus_b.out_valid), 64'd0);

        // Reset with two entries in flight discards both
        push_a(ADDI);
        push_a(SW);
        out_a("pre_rst", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        reset          = 1'b1;
        bus_a.in_valid = 1'b0;
        step();
        out_a("mid_rst", 1'b0, 32'h0, 3'd0, 1'b0);
        out_b("mid_rst_b", 1'b0, 64'h0, 3'd0);
        reset = 1'b0;
        step();
        chk("post_rst_rdy", 64'(bus_a.in_ready), 64'd1);
        step();
        chk("post_rst_flushed", 64'(bus_a.out_valid), 64'd0);

        push_a(CSRWI);
        idle_a();
`ifdef IMMGEN_CSR_EN
        out_a("csrrwi", 1'b1, 32'h00000001, 3'd7, 1'b0);
`else
        out_a("csrrwi", 1'b1, 32'h0, 3'd0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
